// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-word holding buffer.
// Define SERIALIZER_LAST_EN to add the o_dout_last final-beat flag.
module piso_serializer #(
  parameter int WORD_WIDTH = 24,
  parameter int LANES      = 1,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [WORD_WIDTH-1:0] iv_din,
  input  logic                  i_din_valid,
  output logic                  o_din_ready,
  output logic [LANES-1:0]      ov_dout,
  output logic                  o_dout_valid
`ifdef SERIALIZER_LAST_EN
  ,
  output logic                  o_dout_last
`endif
);

  localparam int BEATS = WORD_WIDTH / LANES;
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  if (WORD_WIDTH % LANES != 0) begin : g_bad_div
    $error("piso_serializer: LANES must divide WORD_WIDTH");
  end
  if (LANES < 1 || LANES >= WORD_WIDTH) begin : g_bad_lanes
    $error("piso_serializer: need 1 <= LANES < WORD_WIDTH");
  end

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] sreg;
  logic [WORD_WIDTH-1:0] hold;
  logic                  hold_full;
  logic [CW-1:0]         cnt;

  logic                  accept;
  logic                  at_last;
  logic                  advance;
  logic                  load;
  logic [WORD_WIDTH-1:0] load_word;

  function automatic logic [LANES-1:0] head(
    input logic [WORD_WIDTH-1:0] w
  );
    if (MSB_FIRST) return w[WORD_WIDTH-1 -: LANES];
    else return w[LANES-1:0];
  endfunction

  function automatic logic [WORD_WIDTH-1:0] tail(
    input logic [WORD_WIDTH-1:0] w
  );
    if (MSB_FIRST) return w << LANES;
    else return w >> LANES;
  endfunction

  assign o_din_ready = i_en && !hold_full;
  assign accept      = i_din_valid && o_din_ready;
  assign at_last     = (cnt == LAST_BEAT);
  assign advance     = (state == SHIFT) && !at_last;

  // Buffered word wins on the last beat; otherwise a fresh word bypasses.
  always_comb begin
    load      = 1'b0;
    load_word = iv_din;
    unique case (state)
      IDLE: begin
        load = accept;
      end
      SHIFT: begin
        if (at_last) begin
          if (hold_full) begin
            load      = 1'b1;
            load_word = hold;
          end else begin
            load = accept;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      sreg         <= '0;
      hold         <= '0;
      hold_full    <= 1'b0;
      cnt          <= '0;
      ov_dout      <= '0;
      o_dout_valid <= 1'b0;
    end else if (i_en) begin
      if (load) begin
        state        <= SHIFT;
        sreg         <= tail(load_word);
        ov_dout      <= head(load_word);
        cnt          <= '0;
        o_dout_valid <= 1'b1;
      end else if (advance) begin
        sreg    <= tail(sreg);
        ov_dout <= head(sreg);
        cnt     <= cnt + CW'(1);
      end else if (state == SHIFT) begin
        state        <= IDLE;
        ov_dout      <= '0;
        o_dout_valid <= 1'b0;
        cnt          <= '0;
      end

      if (state == SHIFT && at_last && hold_full) begin
        hold_full <= 1'b0;
      end else if (accept && advance) begin
        hold      <= iv_din;
        hold_full <= 1'b1;
      end
    end
  end

`ifdef SERIALIZER_LAST_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dout_last <= 1'b0;
    end else if (i_en) begin
      if (load) begin
        o_dout_last <= (BEATS == 1);
      end else if (advance) begin
        o_dout_last <= ((cnt + CW'(1)) == LAST_BEAT);
      end else begin
        o_dout_last <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer across several lane configurations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_piso_serializer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [23:0] din;
  logic        din_valid;

  logic        rdy1, val1;
  logic [0:0]  dout1;
  logic        rdy4, val4;
  logic [3:0]  dout4;
  logic        rdy4m, val4m;
  logic [3:0]  dout4m;
  logic        rdy8, val8;
  logic [7:0]  dout8;
`ifdef SERIALIZER_LAST_EN
  logic        last1, last4, last4m, last8;
`endif

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  piso_serializer #(.WORD_WIDTH(24), .LANES(1), .MSB_FIRST(1'b0)) u1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .iv_din(din),
    .i_din_valid(din_valid), .o_din_ready(rdy1),
    .ov_dout(dout1), .o_dout_valid(val1)
`ifdef SERIALIZER_LAST_EN
    , .o_dout_last(last1)
`endif
  );

  piso_serializer #(.WORD_WIDTH(24), .LANES(4), .MSB_FIRST(1'b0)) u4 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .iv_din(din),
    .i_din_valid(din_valid), .o_din_ready(rdy4),
    .ov_dout(dout4), .o_dout_valid(val4)
`ifdef SERIALIZER_LAST_EN
    , .o_dout_last(last4)
`endif
  );

  piso_serializer #(.WORD_WIDTH(24), .LANES(4), .MSB_FIRST(1'b1)) u4m (
    .i_clk(clk), .i_rst(rst), .i_en(en), .iv_din(din),
    .i_din_valid(din_valid), .o_din_ready(rdy4m),
    .ov_dout(dout4m), .o_dout_valid(val4m)
`ifdef SERIALIZER_LAST_EN
    , .o_dout_last(last4m)
`endif
  );

  piso_serializer #(.WORD_WIDTH(24), .LANES(8), .MSB_FIRST(1'b0)) u8 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .iv_din(din),
    .i_din_valid(din_valid), .o_din_ready(rdy8),
    .ov_dout(dout8), .o_dout_valid(val8)
`ifdef SERIALIZER_LAST_EN
    , .o_dout_last(last8)
`endif
  );

  task automatic reset_dut();
    @(negedge clk);
    rst       = 1'b1;
    en        = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (val1 !== 1'b0 || dout1 !== 1'b0) begin
      failures++;
      $display("FAIL rst_u1 val=%b dout=%b exp val=0 dout=0", val1, dout1);
    end
    checks++;
    if (val4 !== 1'b0 || dout4 !== 4'h0 || rdy4 !== 1'b1) begin
      failures++;
      $display("FAIL rst_u4 val=%b dout=%h rdy=%b exp 0 0 1", val4, dout4, rdy4);
    end
    checks++;
    if (val8 !== 1'b0 || dout8 !== 8'h00 || rdy8 !== 1'b1) begin
      failures++;
      $display("FAIL rst_u8 val=%b dout=%h rdy=%b exp 0 00 1", val8, dout8, rdy8);
    end
`ifdef SERIALIZER_LAST_EN
    checks++;
    if (last8 !== 1'b0) begin
      failures++;
      $display("FAIL rst_last got=%b exp=0", last8);
    end
`endif
    // reset must win over a low enable
    din       = 24'hFFFFFF;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    checks++;
    if (val4 !== 1'b1 || dout4 !== 4'hF) begin
      failures++;
      $display("FAIL rst_pre_load val=%b dout=%h exp 1 f", val4, dout4);
    end
    en  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    checks++;
    if (val4 !== 1'b0 || dout4 !== 4'h0) begin
      failures++;
      $display("FAIL rst_over_en val=%b dout=%h exp 0 0", val4, dout4);
    end
  endtask

  task automatic test_lanes1();
    logic [23:0] w;
    w = 24'hA5C30F;
    reset_dut();
    din       = w;
    din_valid = 1'b1;
    checks++;
    if (rdy1 !== 1'b1) begin
      failures++;
      $display("FAIL l1_ready got=%b exp=1", rdy1);
    end
    @(negedge clk);
    din_valid = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (val1 !== 1'b1 || dout1 !== w[k]) begin
        failures++;
        $display("FAIL l1_beat%0d val=%b dout=%b exp 1 %b", k, val1, dout1, w[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (val1 !== 1'b0 || dout1 !== 1'b0) begin
      failures++;
      $display("FAIL l1_end val=%b dout=%b exp 0 0", val1, dout1);
    end
  endtask

  task automatic test_lanes4_order();
    logic [3:0] el [6];
    logic [3:0] em [6];
    el = '{4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    em = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    reset_dut();
    din       = 24'h123456;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (val4 !== 1'b1 || dout4 !== el[k]) begin
        failures++;
        $display("FAIL l4_lsb_beat%0d val=%b dout=%h exp 1 %h", k, val4, dout4, el[k]);
      end
      checks++;
      if (val4m !== 1'b1 || dout4m !== em[k]) begin
        failures++;
        $display("FAIL l4_msb_beat%0d val=%b dout=%h exp 1 %h", k, val4m, dout4m, em[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (val4 !== 1'b0 || val4m !== 1'b0 || dout4 !== 4'h0) begin
      failures++;
      $display("FAIL l4_end val=%b valm=%b dout=%h exp 0 0 0", val4, val4m, dout4);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e [12];
    logic       er;
    e = '{4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1,
          4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA};
    reset_dut();
    din       = 24'h123456;
    din_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      er = (k == 0) || (k >= 6);
      checks++;
      if (val4 !== 1'b1 || dout4 !== e[k] || rdy4 !== er) begin
        failures++;
        $display("FAIL b2b_beat%0d val=%b dout=%h rdy=%b exp 1 %h %b",
                 k, val4, dout4, rdy4, e[k], er);
      end
      if (k == 0) din = 24'hABCDEF;
      if (k == 1) din_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (val4 !== 1'b0 || rdy4 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end val=%b rdy=%b exp 0 1", val4, rdy4);
    end
  endtask

  task automatic test_enable();
    reset_dut();
    din       = 24'h123456;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    checks++;
    if (dout4 !== 4'h6) begin
      failures++;
      $display("FAIL en_beat0 dout=%h exp=6", dout4);
    end
    @(negedge clk);
    checks++;
    if (dout4 !== 4'h5) begin
      failures++;
      $display("FAIL en_beat1 dout=%h exp=5", dout4);
    end
    @(negedge clk);
    checks++;
    if (dout4 !== 4'h4) begin
      failures++;
      $display("FAIL en_beat2 dout=%h exp=4", dout4);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (val4 !== 1'b1 || dout4 !== 4'h4 || rdy4 !== 1'b0) begin
        failures++;
        $display("FAIL en_hold%0d val=%b dout=%h rdy=%b exp 1 4 0",
                 i, val4, dout4, rdy4);
      end
    end
    en = 1'b1;
    for (int k = 3; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (val4 !== 1'b1 || dout4 !== 4'(6 - k)) begin
        failures++;
        $display("FAIL en_beat%0d val=%b dout=%h exp 1 %h", k, val4, dout4, 4'(6 - k));
      end
    end
    @(negedge clk);
    checks++;
    if (val4 !== 1'b0) begin
      failures++;
      $display("FAIL en_end val=%b exp=0", val4);
    end
  endtask

  task automatic test_reset_midstream();
    logic seen;
    reset_dut();
    din       = 24'h123456;
    din_valid = 1'b1;
    @(negedge clk);
    din = 24'hABCDEF;
    @(negedge clk);
    din_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dout4 !== 4'h3 || rdy4 !== 1'b0) begin
      failures++;
      $display("FAIL mid_pre dout=%h rdy=%b exp 3 0", dout4, rdy4);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (val4 !== 1'b0 || dout4 !== 4'h0 || rdy4 !== 1'b1) begin
      failures++;
      $display("FAIL mid_rst val=%b dout=%h rdy=%b exp 0 0 1", val4, dout4, rdy4);
    end
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (val4 || val4m) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL mid_replay seen=%b exp=0", seen);
    end
  endtask

  task automatic test_last();
    logic [7:0] ed;
    logic       el;
    reset_dut();
    din       = 24'h000000;
    din_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) din_valid = 1'b0;
      ed = (k < 3) ? 8'h00 : 8'hFF;
      el = (k == 2) || (k == 5);
      checks++;
      if (val8 !== 1'b1 || dout8 !== ed) begin
        failures++;
        $display("FAIL l8_beat%0d val=%b dout=%h exp 1 %h", k, val8, dout8, ed);
      end
`ifdef SERIALIZER_LAST_EN
      checks++;
      if (last8 !== el) begin
        failures++;
        $display("FAIL l8_last%0d got=%b exp=%b", k, last8, el);
      end
`endif
      if (k == 0) begin
        checks++;
        if (rdy8 !== 1'b1) begin
          failures++;
          $display("FAIL l8_ready got=%b exp=1 el=%b", rdy8, el);
        end
        din = 24'hFFFFFF;
      end
    end
    @(negedge clk);
    checks++;
    if (val8 !== 1'b0 || dout8 !== 8'h00) begin
      failures++;
      $display("FAIL l8_end val=%b dout=%h exp 0 00", val8, dout8);
    end
`ifdef SERIALIZER_LAST_EN
    checks++;
    if (last8 !== 1'b0) begin
      failures++;
      $display("FAIL l8_last_end got=%b exp=0", last8);
    end
`endif
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    en        = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    test_reset();
    test_lanes1();
    test_lanes4_order();
    test_back_to_back();
    test_enable();
    test_reset_midstream();
    test_last();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
